jtdd_mcu_ctrl: RTL and testbench

JTDD_MCU_CTRL -- requirements
Module: jtdd_mcu_ctrl

---
 rtl/jtdd_pkg.sv | 37 +++
 rtl/jtdd_pulse.sv | 37 +++
 rtl/jtdd_mcu_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_jtdd_mcu_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtdd_pkg.sv
// Shared definitions for the JTDD MCU control block.
// Holds the shared-RAM arbitration state encoding, the bit positions of the
// control register (written by the main CPU) and of the status byte (read by
// the main CPU), plus a helper that assembles the status byte.
package jtdd_pkg;

   // Shared-RAM arbitration states
   typedef enum logic [1:0] {
      ARB_IDLE     = 2'd0,
      ARB_WAIT     = 2'd1,
      ARB_GRANT    = 2'd2,
      ARB_TMO_HALT = 2'd3
   } arb_state_e;

   // Control register bits (main CPU write)
   localparam int CTL_HALT_BIT   = 0;
   localparam int CTL_NMI_BIT    = 1;
   localparam int CTL_TMOCLR_BIT = 7;

   // Status byte bits (main CPU read): {tmo_flag, 4'b0, main_irq, mcu_ban, mcu_halt}
   localparam int ST_HALT_BIT = 0;
   localparam int ST_BAN_BIT  = 1;
   localparam int ST_IRQ_BIT  = 2;
   localparam int ST_TMO_BIT  = 7;

   function automatic logic [7:0] pack_status(input logic tmo, input logic irq,
                                              input logic ban, input logic halt);
      logic [7:0] st;
      st              = 8'h00;
      st[ST_TMO_BIT]  = tmo;
      st[ST_IRQ_BIT]  = irq;
      st[ST_BAN_BIT]  = ban;
      st[ST_HALT_BIT] = halt;
      return st;
   endfunction

endpackage

// File: rtl/jtdd_pulse.sv
// Retriggerable pulse stretcher.
// A one-cycle trig_i starts a pulse on pulse_o at the next clk edge that lasts
// exactly LEN clk cycles. A trigger during an active pulse restarts the count.
// Ports:
//   clk     in  clock
//   rst     in  asynchronous active-high reset (pulse aborted, count 0)
//   trig_i  in  start / restart request
//   pulse_o out stretched pulse
module jtdd_pulse #(
   parameter int LEN = 4   // 1..15
) (
   input  logic clk,
   input  logic rst,
   input  logic trig_i,
   output logic pulse_o
);

   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (trig_i)
         cnt_d = 4'(LEN);
      else if (cnt_q != 4'd0)
         cnt_d = cnt_q - 4'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= 4'd0;
      else
         cnt_q <= cnt_d;
   end

   assign pulse_o = (cnt_q != 4'd0);

endmodule

// File: rtl/jtdd_mcu_ctrl.sv
// Main CPU <-> MCU control block.
// Provides the main CPU control/status register (MCU halt, MCU NMI trigger,
// timeout flag clear), arbitrates main CPU access to the RAM shared with the
// MCU, and latches the MCU's interrupt request towards the main CPU.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   cen            main CPU clock enable (paces the timeout counter and writes)
//   ctl_cs         control/status register select
//   req_cs         raw shared-RAM window select
//   cpu_wrn        write strobe, active-low
//   cpu_dout[7:0]  main CPU write data
//   mcu_ban        MCU currently owns the shared bus
//   mcu_irqmain    MCU interrupt request level
//   irq_ack        main CPU interrupt acknowledge pulse
//   com_cs         gated shared-RAM select towards the MCU block
//   cpu_waitn      main CPU wait, low = stall
//   mcu_halt       MCU halt request
//   mcu_nmi_set    MCU NMI trigger pulse (NMI_LEN clk long)
//   main_irq       latched interrupt to main CPU
//   st_dout[7:0]   status byte, zero unless ctl_cs
//   arb_state      arbitration FSM state (debug observation)
//
// Handshake: req_cs is the main CPU's request; cpu_waitn is the ready. An
// access completes only in a cycle where req_cs=1 and cpu_waitn=1, and only
// then is com_cs driven high. While cpu_waitn=0 the CPU must hold req_cs.
module jtdd_mcu_ctrl
   import jtdd_pkg::*;
#(
   parameter int NMI_LEN = 4,    // 1..15 clk cycles
   parameter int TMO     = 255   // 1..255 cen cycles
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cen,
   input  logic       ctl_cs,
   input  logic       req_cs,
   input  logic       cpu_wrn,
   input  logic [7:0] cpu_dout,
   input  logic       mcu_ban,
   input  logic       mcu_irqmain,
   input  logic       irq_ack,
   output logic       com_cs,
   output logic       cpu_waitn,
   output logic       mcu_halt,
   output logic       mcu_nmi_set,
   output logic       main_irq,
   output logic [7:0] st_dout,
   output arb_state_e arb_state
);

   arb_state_e state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       tmo_set;
   logic       com_cs_d, waitn_d;

   logic       halt_q;
   logic       nmi_bit_q;
   logic       tmo_q;
   logic       irq_q;
   logic       irq_hist_q;

   logic       ctl_wr;
   logic       nmi_fire;
   logic       irq_rise;
   logic       unused_dout;

   assign ctl_wr      = ctl_cs & ~cpu_wrn & cen;
   // NMI fires only on a 0->1 change of the written bit, so repeated writes
   // of the same value do not retrigger the MCU.
   assign nmi_fire    = ctl_wr & cpu_dout[CTL_NMI_BIT] & ~nmi_bit_q;
   assign irq_rise    = mcu_irqmain & ~irq_hist_q;
   assign unused_dout = ^cpu_dout[6:2];

   // ---------------- arbitration FSM ----------------
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tmo_set  = 1'b0;
      com_cs_d = 1'b0;
      waitn_d  = 1'b1;
      unique case (state_q)
         ARB_IDLE: begin
            if (req_cs) begin
               if (mcu_ban) begin
                  // Stall in the very cycle the request appears so the CPU
                  // never sees a one-cycle ready while the MCU holds the bus.
                  waitn_d = 1'b0;
                  state_d = ARB_WAIT;
                  cnt_d   = 8'd0;
               end else begin
                  com_cs_d = 1'b1;
                  state_d  = ARB_GRANT;
               end
            end
         end
         ARB_WAIT: begin
            waitn_d = 1'b0;
            if (!mcu_ban) begin
               state_d = ARB_GRANT;
            end else if (!req_cs) begin
               state_d = ARB_IDLE;
            end else if (cen) begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_d == 8'(TMO)) begin
                  state_d = ARB_TMO_HALT;
                  tmo_set = 1'b1;
               end
            end
         end
         ARB_TMO_HALT: begin
            waitn_d = 1'b0;
            if (!mcu_ban)
               state_d = ARB_GRANT;
         end
         ARB_GRANT: begin
            // The grant stands even if mcu_ban rises now; the MCU block
            // resolves that conflict on its side.
            com_cs_d = req_cs;
            if (!req_cs)
               state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // ---------------- control / status registers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         halt_q    <= 1'b0;
         nmi_bit_q <= 1'b0;
         tmo_q     <= 1'b0;
      end else begin
         if (ctl_wr) begin
            halt_q    <= cpu_dout[CTL_HALT_BIT];
            nmi_bit_q <= cpu_dout[CTL_NMI_BIT];
         end
         // A fresh timeout wins over a simultaneous clear.
         if (tmo_set)
            tmo_q <= 1'b1;
         else if (ctl_wr && cpu_dout[CTL_TMOCLR_BIT])
            tmo_q <= 1'b0;
      end
   end

   // ---------------- MCU -> main CPU interrupt ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_hist_q <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         irq_hist_q <= mcu_irqmain;
         // Set has priority so an edge coinciding with an ack is not lost.
         if (irq_rise)
            irq_q <= 1'b1;
         else if (irq_ack)
            irq_q <= 1'b0;
      end
   end

   jtdd_pulse #(.LEN(NMI_LEN)) u_nmi (
      .clk     (clk),
      .rst     (rst),
      .trig_i  (nmi_fire),
      .pulse_o (mcu_nmi_set)
   );

   // Combinational FSM outputs are forced to their idle values during reset,
   // since IDLE with req_cs & mcu_ban would otherwise stall the CPU.
   assign com_cs    = com_cs_d & ~rst;
   assign cpu_waitn = waitn_d | rst;
   assign mcu_halt  = halt_q | (state_q == ARB_TMO_HALT);
   assign main_irq  = irq_q;
   assign arb_state = state_q;
   assign st_dout   = ctl_cs ? pack_status(tmo_q, irq_q, mcu_ban, mcu_halt) : 8'h00;

endmodule

// File: tb/tb_jtdd_mcu_ctrl.sv
module tb_jtdd_mcu_ctrl;
   import jtdd_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       cen = 1'b0, ctl_cs = 1'b0, req_cs = 1'b0, cpu_wrn = 1'b1;
   logic [7:0] cpu_dout = 8'h00;
   logic       mcu_ban = 1'b0, mcu_irqmain = 1'b0, irq_ack = 1'b0;

   // default-parameter instance
   logic       com_cs, cpu_waitn, mcu_halt, mcu_nmi_set, main_irq;
   logic [7:0] st_dout;
   arb_state_e arb_state;

   // short-timeout instance (TMO=8), shares all inputs
   logic       com_cs_t, cpu_waitn_t, mcu_halt_t, mcu_nmi_set_t, main_irq_t;
   logic [7:0] st_dout_t;
   arb_state_e arb_state_t;

   int errors = 0;
   int checks = 0;

   jtdd_mcu_ctrl dut (
      .clk(clk), .rst(rst), .cen(cen), .ctl_cs(ctl_cs), .req_cs(req_cs),
      .cpu_wrn(cpu_wrn), .cpu_dout(cpu_dout), .mcu_ban(mcu_ban),
      .mcu_irqmain(mcu_irqmain), .irq_ack(irq_ack), .com_cs(com_cs),
      .cpu_waitn(cpu_waitn), .mcu_halt(mcu_halt), .mcu_nmi_set(mcu_nmi_set),
      .main_irq(main_irq), .st_dout(st_dout), .arb_state(arb_state)
   );

   jtdd_mcu_ctrl #(.NMI_LEN(4), .TMO(8)) dut_t (
      .clk(clk), .rst(rst), .cen(cen), .ctl_cs(ctl_cs), .req_cs(req_cs),
      .cpu_wrn(cpu_wrn), .cpu_dout(cpu_dout), .mcu_ban(mcu_ban),
      .mcu_irqmain(mcu_irqmain), .irq_ack(irq_ack), .com_cs(com_cs_t),
      .cpu_waitn(cpu_waitn_t), .mcu_halt(mcu_halt_t), .mcu_nmi_set(mcu_nmi_set_t),
      .main_irq(main_irq_t), .st_dout(st_dout_t), .arb_state(arb_state_t)
   );

   // ---------------- driver tasks ----------------
   // Inputs change 1 ns after the rising edge; outputs are sampled on the
   // falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ctl_write(input logic [7:0] d);
      ctl_cs = 1'b1; cpu_wrn = 1'b0; cpu_dout = d; cen = 1'b1;
      tick();
      ctl_cs = 1'b0; cpu_wrn = 1'b1; cpu_dout = 8'h00;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      req_cs = 1'b1; mcu_ban = 1'b1;   // would stall if reset did not mask it
      tick();
      @(negedge clk);
      checks++;
      if ({com_cs, cpu_waitn, mcu_halt, mcu_nmi_set, main_irq} !== 5'b01000) begin
         errors++;
         $display("FAIL reset_outputs: got {com,waitn,halt,nmi,irq}=%b expected 01000",
                  {com_cs, cpu_waitn, mcu_halt, mcu_nmi_set, main_irq});
      end
      checks++;
      if (st_dout !== 8'h00) begin
         errors++;
         $display("FAIL reset_st_dout_no_cs: got %h expected 00", st_dout);
      end
      req_cs = 1'b0; mcu_ban = 1'b0;
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_nmi();
      int high_cnt;
      int first_hi;
      ctl_write(8'h02);
      @(negedge clk);
      first_hi = mcu_nmi_set;
      high_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 0) high_cnt = first_hi;
         // count the sample taken right after the write plus the following ones
         if (mcu_nmi_set) high_cnt++;
      end
      checks++;
      if (first_hi !== 1) begin
         errors++;
         $display("FAIL nmi_start: got %0d expected 1 right after write", first_hi);
      end
      checks++;
      if (high_cnt !== 4) begin
         errors++;
         $display("FAIL nmi_length: got %0d cycles expected 4", high_cnt);
      end
      #1;
      // Second identical write must not retrigger.
      ctl_write(8'h02);
      high_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (mcu_nmi_set) high_cnt++;
      end
      checks++;
      if (high_cnt !== 0) begin
         errors++;
         $display("FAIL nmi_repeat_write: got %0d pulse cycles expected 0", high_cnt);
      end
      #1;
      // Restart: fire, clear bit, fire again 2 cycles after the first.
      ctl_write(8'h00);
      ctl_write(8'h02);
      high_cnt = 0;
      @(negedge clk);
      if (mcu_nmi_set) high_cnt++;
      #1;
      ctl_write(8'h00);
      @(negedge clk);
      if (mcu_nmi_set) high_cnt++;
      #1;
      ctl_write(8'h02);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (mcu_nmi_set) high_cnt++;
      end
      checks++;
      if (high_cnt !== 6) begin
         errors++;
         $display("FAIL nmi_restart: got %0d pulse cycles expected 6", high_cnt);
      end
      #1;
      ctl_write(8'h00);
   endtask

   task automatic test_halt();
      mcu_ban = 1'b0;
      ctl_write(8'h01);
      ctl_cs = 1'b1;
      @(negedge clk);
      checks++;
      if (mcu_halt !== 1'b1) begin
         errors++;
         $display("FAIL halt_set: got %b expected 1", mcu_halt);
      end
      checks++;
      if (st_dout !== 8'h01) begin
         errors++;
         $display("FAIL halt_status: got %h expected 01", st_dout);
      end
      #1;
      ctl_cs = 1'b0;
      ctl_write(8'h00);
      @(negedge clk);
      checks++;
      if (mcu_halt !== 1'b0) begin
         errors++;
         $display("FAIL halt_clear: got %b expected 0", mcu_halt);
      end
      #1;
   endtask

   task automatic test_wait();
      int leaks;
      do_reset();
      cen = 1'b0;
      req_cs = 1'b1; mcu_ban = 1'b1;
      #1;
      checks++;
      if (cpu_waitn !== 1'b0 || com_cs !== 1'b0) begin
         errors++;
         $display("FAIL wait_no_leak: got waitn=%b com=%b expected 0 0", cpu_waitn, com_cs);
      end
      leaks = 0;
      for (int i = 0; i < 10; i++) begin
         cen = 1'b1;
         @(posedge clk); #1;
         cen = 1'b0;
         @(negedge clk);
         if (cpu_waitn !== 1'b0 || com_cs !== 1'b0) leaks++;
         @(posedge clk); #1;
         if (cpu_waitn !== 1'b0 || com_cs !== 1'b0) leaks++;
      end
      checks++;
      if (leaks !== 0) begin
         errors++;
         $display("FAIL wait_hold_10cen: got %0d ready samples expected 0", leaks);
      end
      mcu_ban = 1'b0;
      #1;
      checks++;
      if (com_cs !== 1'b0) begin
         errors++;
         $display("FAIL wait_release_same_cycle: got com=%b expected 0", com_cs);
      end
      tick();
      @(negedge clk);
      checks++;
      if (com_cs !== 1'b1 || cpu_waitn !== 1'b1) begin
         errors++;
         $display("FAIL wait_grant: got com=%b waitn=%b expected 1 1", com_cs, cpu_waitn);
      end
      #1;
      mcu_ban = 1'b1;   // must not revoke the grant
      tick();
      @(negedge clk);
      checks++;
      if (com_cs !== 1'b1 || cpu_waitn !== 1'b1) begin
         errors++;
         $display("FAIL grant_kept_on_ban: got com=%b waitn=%b expected 1 1", com_cs, cpu_waitn);
      end
      #1;
      req_cs = 1'b0; mcu_ban = 1'b0;
      tick();
      @(negedge clk);
      checks++;
      if (com_cs !== 1'b0 || cpu_waitn !== 1'b1) begin
         errors++;
         $display("FAIL grant_to_idle: got com=%b waitn=%b expected 0 1", com_cs, cpu_waitn);
      end
      #1;
   endtask

   task automatic test_timeout();
      int early;
      do_reset();
      cen = 1'b1;
      req_cs = 1'b1; mcu_ban = 1'b1;
      tick();                     // IDLE -> WAIT, counter cleared
      early = 0;
      for (int i = 0; i < 7; i++) begin
         tick();
         @(negedge clk);
         if (mcu_halt_t !== 1'b0) early++;
      end
      checks++;
      if (early !== 0) begin
         errors++;
         $display("FAIL tmo_not_early: got %0d halted samples expected 0", early);
      end
      tick();                     // 8th cen
      ctl_cs = 1'b1;
      @(negedge clk);
      checks++;
      if (mcu_halt_t !== 1'b1 || cpu_waitn_t !== 1'b0 || st_dout_t !== 8'h83) begin
         errors++;
         $display("FAIL tmo_halt: got halt=%b waitn=%b st=%h expected 1 0 83",
                  mcu_halt_t, cpu_waitn_t, st_dout_t);
      end
      #1;
      mcu_ban = 1'b0;
      tick();
      @(negedge clk);
      checks++;
      if (com_cs_t !== 1'b1 || cpu_waitn_t !== 1'b1 || mcu_halt_t !== 1'b0 || st_dout_t !== 8'h80) begin
         errors++;
         $display("FAIL tmo_grant: got com=%b waitn=%b halt=%b st=%h expected 1 1 0 80",
                  com_cs_t, cpu_waitn_t, mcu_halt_t, st_dout_t);
      end
      #1;
      req_cs = 1'b0;
      ctl_cs = 1'b0;
      tick();
      ctl_write(8'h80);
      ctl_cs = 1'b1;
      @(negedge clk);
      checks++;
      if (st_dout_t !== 8'h00) begin
         errors++;
         $display("FAIL tmo_clear: got st=%h expected 00", st_dout_t);
      end
      #1;
      ctl_cs = 1'b0;
   endtask

   task automatic test_irq();
      mcu_irqmain = 1'b1; irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      @(negedge clk);
      checks++;
      if (main_irq !== 1'b1) begin
         errors++;
         $display("FAIL irq_set_vs_ack: got %b expected 1", main_irq);
      end
      #1;
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      tick();
      tick();
      @(negedge clk);
      checks++;
      if (main_irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_ack_clear: got %b expected 0 (level held, no new edge)", main_irq);
      end
      #1;
      mcu_irqmain = 1'b0;
      tick();
      mcu_irqmain = 1'b1;
      #1;
      checks++;
      if (main_irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_latency: got %b expected 0 before the edge", main_irq);
      end
      tick();
      @(negedge clk);
      checks++;
      if (main_irq !== 1'b1) begin
         errors++;
         $display("FAIL irq_rise: got %b expected 1", main_irq);
      end
      #1;
   endtask

   task automatic test_reset_abort();
      int residual;
      // main_irq is still set from the previous test
      ctl_write(8'h02);           // NMI pulse running
      req_cs = 1'b1; mcu_ban = 1'b1;
      tick();                     // WAIT
      tick();
      rst = 1'b1;
      #1;
      checks++;
      if ({com_cs, cpu_waitn, mcu_halt, mcu_nmi_set, main_irq} !== 5'b01000) begin
         errors++;
         $display("FAIL reset_abort: got {com,waitn,halt,nmi,irq}=%b expected 01000",
                  {com_cs, cpu_waitn, mcu_halt, mcu_nmi_set, main_irq});
      end
      req_cs = 1'b0; mcu_ban = 1'b0; mcu_irqmain = 1'b0;
      tick();
      rst = 1'b0;
      residual = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (mcu_nmi_set !== 1'b0 || cpu_waitn !== 1'b1 || com_cs !== 1'b0) residual++;
      end
      checks++;
      if (residual !== 0) begin
         errors++;
         $display("FAIL reset_no_residual: got %0d active samples expected 0", residual);
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_nmi();
      test_halt();
      test_wait();
      test_timeout();
      test_irq();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
